// File: rtl/instr_cache_pkg.sv
// Shared fetch-pipeline definitions for the instruction cache.
//   FETCH_W / SLOT_W : fetch word and instruction slot widths
//   *_SLOT_LSB       : bit positions of the ALU and MEM slots in a fetch word
//   ic_state_e       : refill controller state encoding
package instr_cache_pkg;

  localparam int FETCH_W      = 32;
  localparam int SLOT_W       = 16;
  localparam int ALU_SLOT_LSB = 16;
  localparam int MEM_SLOT_LSB = 0;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_FILLED = 2'd2
  } ic_state_e;

endpackage

// File: rtl/instr_cache_if.sv
// Fetch and refill bus of the instruction cache.
//   pc, inv_all             : fetch-stage request and invalidate-all
//   hit, instr2Word         : lookup result (hit is the fetch stall source)
//   mem_req, mem_addr       : line refill request towards backing memory
//   mem_rvalid, mem_rdata   : refill beats from backing memory
//   miss_count              : saturating refill counter
// slave = cache side, master = fetch stage / backing memory side.
interface instr_cache_if;
  import instr_cache_pkg::*;

  logic [31:0]        pc;
  logic               inv_all;
  logic               hit;
  logic [FETCH_W-1:0] instr2Word;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_rvalid;
  logic [31:0]        mem_rdata;
  logic [15:0]        miss_count;

  modport slave (
    input  pc, inv_all, mem_rvalid, mem_rdata,
    output hit, instr2Word, mem_req, mem_addr, miss_count
  );

  modport master (
    output pc, inv_all, mem_rvalid, mem_rdata,
    input  hit, instr2Word, mem_req, mem_addr, miss_count
  );

endinterface

// File: rtl/instr_cache_refill_fsm.sv
// Refill controller of the instruction cache.
// Owns the state, beat counter, drop flag, refill request/address and the
// miss counter; tells the cache top when and where to write each beat and
// when to install the line.
//   clk, reset     : clock, asynchronous active-low reset
//   i_miss         : current lookup missed and no invalidate is pending
//   i_miss_addr    : line-aligned address of the missing line
//   i_inv_all      : invalidate-all request
//   i_rvalid       : refill beat present
//   o_state        : controller state (lookup only answers in IC_IDLE)
//   o_wr_en/o_beat : write the current beat into word o_beat of the line
//   o_install      : set tag/valid for the line being refilled
//   o_mem_req/addr : refill request towards backing memory
//   o_miss_count   : saturating count of refills started
//
// state     | meaning
// IC_IDLE   | lookup active; a miss starts a refill
// IC_REFILL | mem_req high, collecting WORDS_PER_LINE beats
// IC_FILLED | one bubble cycle after install, hit forced low
module ic_refill_fsm
  import instr_cache_pkg::*;
#(
  parameter  int WORDS_PER_LINE = 4,
  localparam int OFF_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_miss,
  input  logic [31:0]      i_miss_addr,
  input  logic             i_inv_all,
  input  logic             i_rvalid,
  output ic_state_e        o_state,
  output logic             o_wr_en,
  output logic [OFF_W-1:0] o_beat,
  output logic             o_install,
  output logic             o_mem_req,
  output logic [31:0]      o_mem_addr,
  output logic [15:0]      o_miss_count
);

  ic_state_e        r_state;
  ic_state_e        w_next_state;
  logic [OFF_W-1:0] r_beat;
  logic             r_drop;
  logic             r_mem_req;
  logic [31:0]      r_mem_addr;
  logic [15:0]      r_miss_count;
  logic             w_start;
  logic             w_last;
  logic             w_wr_en;
  logic             w_install;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_last       = 1'b0;
    w_wr_en      = 1'b0;
    w_install    = 1'b0;
    case (r_state)
      IC_IDLE: begin
        if (i_miss) begin
          w_start      = 1'b1;
          w_next_state = IC_REFILL;
        end
      end
      IC_REFILL: begin
        if (i_rvalid) begin
          w_wr_en = 1'b1;
          if (r_beat == OFF_W'(WORDS_PER_LINE - 1)) begin
            w_last       = 1'b1;
            // An invalidate on the final beat must also prevent the install.
            w_install    = !r_drop && !i_inv_all;
            w_next_state = IC_FILLED;
          end
        end
      end
      IC_FILLED: w_next_state = IC_IDLE;
      default:   w_next_state = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IC_IDLE;
      r_beat       <= '0;
      r_drop       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= i_miss_addr;
        r_beat     <= '0;
        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
      end
      // Beat counter wraps back to zero on the last beat.
      if (w_wr_en) r_beat <= r_beat + 1'b1;
      if (w_last)  r_mem_req <= 1'b0;
      if (r_state == IC_REFILL && i_inv_all) r_drop <= 1'b1;
      else if (r_state == IC_FILLED)         r_drop <= 1'b0;
    end
  end

  assign o_state      = r_state;
  assign o_wr_en      = w_wr_en;
  assign o_beat       = r_beat;
  assign o_install    = w_install;
  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_mem_addr;
  assign o_miss_count = r_miss_count;

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache.
// Combinational lookup of pc returns one fetch word per cycle; a miss refills
// the whole line through ic_refill_fsm.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : instr_cache_if slave (fetch lookup, refill handshake, miss count)
// Address split: [1:0] byte, then word offset, line index, tag (widths from
// LINES / WORDS_PER_LINE).
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic         clk,
  input  logic         reset,
  instr_cache_if.slave bus
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [FETCH_W-1:0] r_data [LINES][WORDS_PER_LINE];

  logic [OFF_W-1:0]   w_pc_word;
  logic [IDX_W-1:0]   w_pc_idx;
  logic [TAG_W-1:0]   w_pc_tag;
  logic               w_unused_pc_lsb;
  logic               w_lookup_hit;
  logic               w_hit;
  logic [FETCH_W-1:0] w_word;
  logic [SLOT_W-1:0]  w_alu_slot;
  logic [SLOT_W-1:0]  w_mem_slot;

  ic_state_e          w_state;
  logic               w_wr_en;
  logic [OFF_W-1:0]   w_beat;
  logic               w_install;
  logic               w_mem_req;
  logic [31:0]        w_mem_addr;
  logic [15:0]        w_miss_count;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;

  assign w_pc_word       = bus.pc[2 +: OFF_W];
  assign w_pc_idx        = bus.pc[2 + OFF_W +: IDX_W];
  assign w_pc_tag        = bus.pc[31 -: TAG_W];
  assign w_unused_pc_lsb = ^bus.pc[1:0];

  assign w_lookup_hit = r_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag);
  // inv_all suppresses the hit in the same cycle it clears the valid bits.
  assign w_hit = (w_state == IC_IDLE) && w_lookup_hit && !bus.inv_all;

  assign w_word     = r_data[w_pc_idx][w_pc_word];
  assign w_alu_slot = w_word[ALU_SLOT_LSB +: SLOT_W];
  assign w_mem_slot = w_word[MEM_SLOT_LSB +: SLOT_W];

  // The refill target line is taken from the latched request address, so a
  // pc change during refill cannot redirect where the beats land.
  assign w_fill_idx = w_mem_addr[2 + OFF_W +: IDX_W];
  assign w_fill_tag = w_mem_addr[31 -: TAG_W];

  ic_refill_fsm #(
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill (
    .clk          (clk),
    .reset        (reset),
    .i_miss       (!w_lookup_hit && !bus.inv_all),
    .i_miss_addr  ({w_pc_tag, w_pc_idx, {(OFF_W + 2){1'b0}}}),
    .i_inv_all    (bus.inv_all),
    .i_rvalid     (bus.mem_rvalid),
    .o_state      (w_state),
    .o_wr_en      (w_wr_en),
    .o_beat       (w_beat),
    .o_install    (w_install),
    .o_mem_req    (w_mem_req),
    .o_mem_addr   (w_mem_addr),
    .o_miss_count (w_miss_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (bus.inv_all) begin
      r_valid <= '0;
    end else if (w_install) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage are not reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (w_wr_en)   r_data[w_fill_idx][w_beat] <= bus.mem_rdata;
    if (w_install) r_tag[w_fill_idx] <= w_fill_tag;
  end

  assign bus.hit        = w_hit;
  assign bus.instr2Word = w_hit ? {w_alu_slot, w_mem_slot} : '0;
  assign bus.mem_req    = w_mem_req;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.miss_count = w_miss_count;

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } fexp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   gap = 0;
  int   beats_sent = 0;
  int   last_hit_cyc = 0;

  fexp_t       fq[$];
  logic [31:0] mq[$];
  logic [31:0] backing [logic [31:0]];

  instr_cache_if bus();

  instr_cache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Backing memory: serves one line per request, gap idle cycles before each beat.
  initial begin : mem_model
    logic [31:0] ma;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (reset === 1'b1 && bus.mem_req === 1'b1) begin
        ma = bus.mem_addr;
        beats_sent = 0;
        for (int b = 0; b < 4; b++) begin
          bus.mem_rvalid = 1'b0;
          repeat (gap) @(negedge clk);
          if (reset !== 1'b1) break;
          bus.mem_rdata  = mem_word(ma + 32'(4 * b));
          bus.mem_rvalid = 1'b1;
          beats_sent++;
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
      end
    end
  end

  // Fetch monitor: pops an expectation whenever the cache reports a hit.
  initial begin : fetch_mon
    fexp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (bus.hit === 1'b1 && fq.size() > 0) begin
          e = fq.pop_front();
          check("fetch_pc", bus.pc, e.pc);
          check("fetch_word", bus.instr2Word, e.word);
          last_hit_cyc = cyc;
        end
        if (bus.hit !== 1'b1) check("word_zero_when_no_hit", bus.instr2Word, 32'h0);
      end
    end
  end

  // Request monitor: pops expected refill address on each new request,
  // then checks the address is held for the whole request.
  initial begin : req_mon
    logic        prev_req;
    logic [31:0] req_addr;
    prev_req = 1'b0;
    req_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (!prev_req) begin
          if (mq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: got addr %h, expected no request", bus.mem_addr);
          end else begin
            check("req_addr", bus.mem_addr, mq.pop_front());
          end
          req_addr = bus.mem_addr;
        end else begin
          check("req_addr_stable", bus.mem_addr, req_addr);
        end
      end
      prev_req = (bus.mem_req === 1'b1);
    end
  end

  // Issue a fetch: n_miss refills expected, exp_lat cycles to hit (-1 = don't care),
  // inv_beat >= 0 pulses inv_all alongside that beat of the first refill.
  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int n_miss,
                       input int exp_lat, input int inv_beat);
    fexp_t t;
    int    start;
    bit    inv_done;
    inv_done = 1'b0;
    for (int i = 0; i < n_miss; i++) mq.push_back(a & 32'hFFFF_FFF0);
    t.pc   = a;
    t.word = w;
    fq.push_back(t);
    bus.pc = a;
    start  = cyc;
    for (int i = 0; i < 400 && fq.size() > 0; i++) begin
      if (inv_beat >= 0 && !inv_done && bus.mem_req === 1'b1 && beats_sent == inv_beat) begin
        bus.inv_all = 1'b1;
        inv_done = 1'b1;
        step();
        bus.inv_all = 1'b0;
      end else begin
        step();
      end
    end
    if (fq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_timeout: pc %h got no hit, expected hit with %h", a, w);
      fq.delete();
    end else if (exp_lat >= 0) begin
      check("hit_latency", 32'(last_hit_cyc - start), 32'(exp_lat));
    end
  endtask

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < 4; i++) begin
      backing[32'h100 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
      backing[32'h200 + 32'(4 * i)] = 32'hA0 + 32'(i);
      backing[32'h340 + 32'(4 * i)] = 32'hB0 + 32'(i);
      backing[32'h180 + 32'(4 * i)] = 32'hC0DE_0001 + 32'(i);
      backing[32'h480 + 32'(4 * i)] = 32'hD0 + 32'(i);
    end
    bus.pc      = 32'h100;
    bus.inv_all = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_hit", {31'h0, bus.hit}, 32'h0);
    check("rst_word", bus.instr2Word, 32'h0);
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_miss_count", {16'h0, bus.miss_count}, 32'h0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;

    // 1 cold miss, back-to-back beats
    fetch(32'h100, 32'h11, 1, 6, -1);
    fetch(32'h10C, 32'h44, 0, 0, -1);
    check("miss_count_t1", {16'h0, bus.miss_count}, 32'd1);

    // 2 conflict eviction at index 0
    fetch(32'h200, 32'hA0, 1, 6, -1);
    fetch(32'h20C, 32'hA3, 0, 0, -1);
    fetch(32'h100, 32'h11, 1, 6, -1);
    fetch(32'h104, 32'h22, 0, 0, -1);
    check("miss_count_t2", {16'h0, bus.miss_count}, 32'd3);

    // 3 gapped beats
    gap = 2;
    fetch(32'h180, 32'hC0DE_0001, 1, 14, -1);
    gap = 0;
    fetch(32'h184, 32'hC0DE_0002, 0, 0, -1);
    fetch(32'h188, 32'hC0DE_0003, 0, 0, -1);
    fetch(32'h18C, 32'hC0DE_0004, 0, 0, -1);
    check("miss_count_t3", {16'h0, bus.miss_count}, 32'd4);

    // 4 inv_all at beat 2: line dropped, same pc re-requests; old lines lost
    fetch(32'h480, 32'hD0, 2, -1, 2);
    fetch(32'h48C, 32'hD3, 0, 0, -1);
    check("miss_count_t4", {16'h0, bus.miss_count}, 32'd6);
    fetch(32'h100, 32'h11, 1, 6, -1);
    check("miss_count_t4b", {16'h0, bus.miss_count}, 32'd7);

    // inv_all in IDLE on a valid line: hit forced low, no refill that cycle
    bus.pc = 32'h100;
    bus.inv_all = 1'b1;
    #1;
    check("inv_idle_hit", {31'h0, bus.hit}, 32'h0);
    check("inv_idle_word", bus.instr2Word, 32'h0);
    step();
    bus.inv_all = 1'b0;
    #1;
    check("inv_idle_no_req", {31'h0, bus.mem_req}, 32'h0);
    check("inv_idle_cleared", {31'h0, bus.hit}, 32'h0);

    // 5 pc change mid-refill: 0x100 installed, then refill of 0x340
    mq.push_back(32'h100);
    repeat (3) step();
    fetch(32'h340, 32'hB0, 1, -1, -1);
    fetch(32'h100, 32'h11, 0, 0, -1);
    fetch(32'h34C, 32'hB3, 0, 0, -1);
    check("miss_count_t5", {16'h0, bus.miss_count}, 32'd9);

    // 6 async reset mid-refill
    mq.push_back(32'h180);
    bus.pc = 32'h180;
    repeat (3) step();
    check("pre_rst_req", {31'h0, bus.mem_req}, 32'h1);
    #3 reset = 1'b0;
    #1;
    check("async_rst_req", {31'h0, bus.mem_req}, 32'h0);
    check("async_rst_hit", {31'h0, bus.hit}, 32'h0);
    check("async_rst_addr", bus.mem_addr, 32'h0);
    check("async_rst_count", {16'h0, bus.miss_count}, 32'h0);
    bus.pc = 32'h100;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    fetch(32'h100, 32'h11, 1, 6, -1);
    check("miss_count_t6", {16'h0, bus.miss_count}, 32'd1);

    repeat (3) step();
    check("fetch_queue_empty", 32'(fq.size()), 32'd0);
    check("req_queue_empty", 32'(mq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
